// File: rtl/multicycle_adder_subtractor_if.sv
// Operand/result bus for multicycle_adder_subtractor.
// Handshake: a transfer happens on a rising clk edge where valid && ready; the producer keeps its
// payload stable while valid is high and not yet accepted, and ready never depends on valid in the same cycle.
interface multicycle_adder_subtractor_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic         in_sub;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_s;
   logic         out_cout;
   logic         out_ovf;

   modport master (
      output in_valid, in_sub, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_s, out_cout, out_ovf
   );

   modport slave (
      input  in_valid, in_sub, in_a, in_b, out_ready,
      output in_ready, out_valid, out_s, out_cout, out_ovf
   );
endinterface

// File: rtl/multicycle_adder_subtractor.sv
// Chunk-serial adder/subtractor: CHUNK bits per cycle with a registered inter-chunk carry.
// Define ADDSUB_SATURATE_EN to clamp the result to the signed range when overflow is detected.
module multicycle_adder_subtractor #(
   parameter int N     = 32,
   parameter int CHUNK = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   multicycle_adder_subtractor_if.slave   bus,
   output logic [1:0]                     state_dbg
);
   localparam int NCHUNKS = N / CHUNK;
   localparam int CW      = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;

   if (N % CHUNK != 0) begin : g_bad_chunk
      $error("multicycle_adder_subtractor: N must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    a_q, bx_q, s_q;
   logic            sub_q, carry_q, cout_q, ovf_q;
   logic [CW-1:0]   cnt_q;

   logic            accept;
   logic            last_chunk;
   logic [CHUNK:0]  chunk_sum;
   logic [N+CHUNK-1:0] s_cat;
   logic [N-1:0]    s_next;
   logic            ovf_next;

   // Operands are shifted right each cycle so the active chunk always sits in the low bits;
   // on the last chunk those low bits hold the operand sign bits needed for overflow.
   always_comb begin
      accept     = (state_q == IDLE) && bus.in_valid;
      last_chunk = (cnt_q == CW'(NCHUNKS - 1));
      chunk_sum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, bx_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
      s_cat      = {chunk_sum[CHUNK-1:0], s_q};
      ovf_next   = (a_q[CHUNK-1] == bx_q[CHUNK-1]) && (chunk_sum[CHUNK-1] != a_q[CHUNK-1]);
`ifdef ADDSUB_SATURATE_EN
      s_next = s_cat[N+CHUNK-1:CHUNK];
      if (last_chunk && ovf_next) begin
         s_next = a_q[CHUNK-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
`else
      s_next = s_cat[N+CHUNK-1:CHUNK];
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = BUSY;
         BUSY:    if (last_chunk) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         bx_q    <= '0;
         s_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= bus.in_a;
                  bx_q    <= bus.in_b ^ {N{bus.in_sub}};
                  sub_q   <= bus.in_sub;
                  carry_q <= bus.in_sub;
                  cnt_q   <= '0;
               end
            end
            BUSY: begin
               a_q     <= a_q >> CHUNK;
               bx_q    <= bx_q >> CHUNK;
               carry_q <= chunk_sum[CHUNK];
               cnt_q   <= cnt_q + CW'(1);
               s_q     <= s_next;
               if (last_chunk) begin
                  cout_q <= sub_q ^ chunk_sum[CHUNK];
                  ovf_q  <= ovf_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_s     = s_q;
   assign bus.out_cout  = cout_q;
   assign bus.out_ovf   = ovf_q;
   assign state_dbg     = state_q;
endmodule
